// File: rtl/mux41_rr.sv
// mux41_rr: merges four WIDTH-bit valid/ready lanes into one registered stream tagged with the source lane.
// Latency: 1 cycle from lane accept to y_valid; sustains 1 word/cycle when y_ready stays high.
// Backpressure: while y_valid && !y_ready the output is held and no lane is granted (a_ready=0).
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst      - synchronous active-high reset
//   a        - packed lane data, lane i = a[i*WIDTH +: WIDTH]
//   a_valid  - lane i offers a word
//   a_ready  - lane i word accepted this cycle (combinational, one-hot or zero)
//   y        - registered output data
//   y_sel    - source lane index of y
//   y_valid  - y/y_sel hold a word
//   y_ready  - downstream accepts y this cycle
module mux41_rr #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*WIDTH-1:0]   a,
    input  logic [3:0]           a_valid,
    output logic [3:0]           a_ready,
    output logic [WIDTH-1:0]     y,
    output logic [1:0]           y_sel,
    output logic                 y_valid,
    input  logic                 y_ready
);

    // Round-robin pointer: the lane with highest priority in the next search.
    logic [1:0] ptr;

    // The output register can take a new word when empty or when it drains this cycle.
    logic       load;
    logic       found;
    logic [1:0] grant;
    logic       accept;

    assign load = !rst && (!y_valid || y_ready);

    // Priority search starting at ptr. Iterating from the farthest offset down to
    // offset 0 lets the nearest valid lane overwrite any farther candidate.
    // The 2-bit sum wraps naturally, giving the mod-4 rotation.
    always_comb begin
        found = 1'b0;
        grant = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (a_valid[ptr + 2'(k)]) begin
                found = 1'b1;
                grant = ptr + 2'(k);
            end
        end
    end

    assign accept  = found && load;
    assign a_ready = accept ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_sel   <= 2'd0;
            y_valid <= 1'b0;
            ptr     <= 2'd0;
        end else if (accept) begin
            // Covers both the empty case and drain+accept in the same cycle.
            y       <= a[int'(grant)*WIDTH +: WIDTH];
            y_sel   <= grant;
            y_valid <= 1'b1;
            ptr     <= grant + 2'd1;
        end else if (y_valid && y_ready) begin
            // Drain without refill: data and tag keep their last values.
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux41_rr.sv
module tb_mux41_rr;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [4*W-1:0] a;
    logic [3:0]     a_valid;
    logic [3:0]     a_ready;
    logic [W-1:0]   y;
    logic [1:0]     y_sel;
    logic           y_valid;
    logic           y_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural reference state.
    logic [W-1:0] m_y   = '0;
    logic [1:0]   m_sel = 2'd0;
    logic         m_vld = 1'b0;
    int           m_ptr = 0;

    mux41_rr #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .y       (y),
        .y_sel   (y_sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First valid lane scanning ptr, ptr+1, ... (mod 4); -1 if none.
    function automatic int find_lane(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++) begin
            if (v[(p + off) % 4]) return (p + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = find_lane(a_valid, m_ptr);
        if (rst) return 4'b0000;
        if (m_vld && !y_ready) return 4'b0000;
        if (g < 0) return 4'b0000;
        return 4'b0001 << g;
    endfunction

    // Advance one clock; the model takes the inputs as they stand at the edge.
    task automatic tick();
        int g;
        @(posedge clk);
        if (rst) begin
            m_y = '0; m_sel = 2'd0; m_vld = 1'b0; m_ptr = 0;
        end else begin
            g = find_lane(a_valid, m_ptr);
            if ((!m_vld || y_ready) && g >= 0) begin
                m_y   = a[g*W +: W];
                m_sel = 2'(g);
                m_vld = 1'b1;
                m_ptr = (g + 1) % 4;
            end else if (m_vld && y_ready) begin
                m_vld = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 4'b0000; y_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 4'b1111; a = 16'h4321; y_ready = 1'b1;
        #1;
        if (a_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready_in got %b exp 0000", a_ready); end
        n_cmp++;
        tick();
        tick();
        if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
        n_cmp++;
        if (y !== 4'h0) begin n_err++; $display("FAIL reset_y got %h exp 0", y); end
        n_cmp++;
        if (y_sel !== 2'd0) begin n_err++; $display("FAIL reset_y_sel got %0d exp 0", y_sel); end
        n_cmp++;
        rst = 1'b0;
        #1;
        if (a_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b exp 0001", a_ready); end
        n_cmp++;
        tick();
        if (y_valid !== 1'b1 || y_sel !== 2'd0 || y !== 4'h1) begin
            n_err++; $display("FAIL reset_first_word got v=%b sel=%0d y=%h exp v=1 sel=0 y=1", y_valid, y_sel, y);
        end
        n_cmp++;
    endtask

    task automatic test_single_lane();
        do_reset();
        a_valid = 4'b0100; a = 16'h0A00; y_ready = 1'b1;
        #1;
        if (a_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b exp 0100", a_ready); end
        n_cmp++;
        tick();
        if (y !== 4'hA || y_sel !== 2'd2 || y_valid !== 1'b1) begin
            n_err++; $display("FAIL single_word got y=%h sel=%0d v=%b exp y=a sel=2 v=1", y, y_sel, y_valid);
        end
        n_cmp++;
        a_valid = 4'b1111; a = 16'h4321;
        #1;
        if (a_ready !== 4'b1000) begin n_err++; $display("FAIL single_next_search got %b exp 1000", a_ready); end
        n_cmp++;
        tick();
        if (y_sel !== 2'd3 || y !== 4'h4) begin n_err++; $display("FAIL single_next_word got sel=%0d y=%h exp sel=3 y=4", y_sel, y); end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        do_reset();
        a_valid = 4'b1111; a = 16'h4321; y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (y_valid !== 1'b1 || y_sel !== 2'(i % 4) || y !== 4'(i % 4 + 1)) begin
                n_err++;
                $display("FAIL rr_seq[%0d] got v=%b sel=%0d y=%h exp v=1 sel=%0d y=%0d", i, y_valid, y_sel, y, i % 4, i % 4 + 1);
            end
            n_cmp++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 4'b0010; a = 16'h0050; y_ready = 1'b1;
        tick();
        y_ready = 1'b0; a_valid = 4'b1111; a = 16'h4321;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (a_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, a_ready); end
            n_cmp++;
            tick();
            if (y !== 4'h5 || y_sel !== 2'd1 || y_valid !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d] got y=%h sel=%0d v=%b exp y=5 sel=1 v=1", i, y, y_sel, y_valid);
            end
            n_cmp++;
        end
        y_ready = 1'b1;
        #1;
        if (a_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready got %b exp 0100", a_ready); end
        n_cmp++;
        tick();
        if (y_sel !== 2'd2 || y !== 4'h3) begin n_err++; $display("FAIL bp_release_word got sel=%0d y=%h exp sel=2 y=3", y_sel, y); end
        n_cmp++;
    endtask

    task automatic test_drain();
        do_reset();
        a_valid = 4'b1000; a = 16'hF000; y_ready = 1'b1;
        tick();
        if (y !== 4'hF || y_sel !== 2'd3 || y_valid !== 1'b1) begin
            n_err++; $display("FAIL drain_load got y=%h sel=%0d v=%b exp y=f sel=3 v=1", y, y_sel, y_valid);
        end
        n_cmp++;
        a_valid = 4'b0000; a = 16'h1234;
        tick();
        if (y_valid !== 1'b0 || y !== 4'hF || y_sel !== 2'd3) begin
            n_err++; $display("FAIL drain_empty got v=%b y=%h sel=%0d exp v=0 y=f sel=3", y_valid, y, y_sel);
        end
        n_cmp++;
        tick();
        a_valid = 4'b0001; a = 16'h0007;
        #1;
        if (a_ready !== 4'b0001) begin n_err++; $display("FAIL drain_wrap_ready got %b exp 0001", a_ready); end
        n_cmp++;
        tick();
        if (y !== 4'h7 || y_sel !== 2'd0 || y_valid !== 1'b1) begin
            n_err++; $display("FAIL drain_wrap_word got y=%h sel=%0d v=%b exp y=7 sel=0 v=1", y, y_sel, y_valid);
        end
        n_cmp++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        a_valid = 4'b0100; a = 16'h0900; y_ready = 1'b1;
        tick();
        y_ready = 1'b0; a_valid = 4'b1111;
        tick();
        rst = 1'b1;
        #1;
        if (a_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready got %b exp 0000", a_ready); end
        n_cmp++;
        tick();
        rst = 1'b0;
        if (y_valid !== 1'b0 || y !== 4'h0) begin n_err++; $display("FAIL midrst_state got v=%b y=%h exp v=0 y=0", y_valid, y); end
        n_cmp++;
        a_valid = 4'b0110; a = 16'h0CB0; y_ready = 1'b1;
        #1;
        if (a_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_grant got %b exp 0010", a_ready); end
        n_cmp++;
        tick();
        if (y_sel !== 2'd1 || y !== 4'hB) begin n_err++; $display("FAIL midrst_word got sel=%0d y=%h exp sel=1 y=b", y_sel, y); end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [3:0] er;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            a_valid = 4'($urandom);
            a       = 16'($urandom);
            y_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            if (a_ready !== er) begin n_err++; $display("FAIL rand_ready[%0d] got %b exp %b", i, a_ready, er); end
            n_cmp++;
            tick();
            if (y_valid !== m_vld || y !== m_y || y_sel !== m_sel) begin
                n_err++;
                $display("FAIL rand_out[%0d] got v=%b y=%h sel=%0d exp v=%b y=%h sel=%0d", i, y_valid, y, y_sel, m_vld, m_y, m_sel);
            end
            n_cmp++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = '0; a_valid = 4'b0000; y_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
